// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiply and restoring divide,
// UNROLL bits per cycle, with a fast path for divide-by-zero and signed overflow.
module ex_muldiv #(
  parameter int XLEN    = 32,
  parameter int UNROLL  = 1,
  parameter int REGADDR = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [2:0]         op_i,
  input  logic [XLEN-1:0]    rs1_i,
  input  logic [XLEN-1:0]    rs2_i,
  input  logic [REGADDR-1:0] wd_i,
  input  logic               flush_i,
  output logic               stall_req_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [XLEN-1:0]    wdata_o,
  output logic [REGADDR-1:0] wd_o,
  output logic               wreg_o
);

  localparam int N  = XLEN / UNROLL;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
  localparam logic [XLEN-1:0] SMIN     = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;

  state_t state_q, state_d;

  logic [CW-1:0]      cnt_q;
  logic [2:0]         op_q;
  logic [REGADDR-1:0] wd_q;
  logic               neg_q;
  logic [XLEN-1:0]    opnd_q;
  logic [XLEN-1:0]    hi_q;
  logic [XLEN-1:0]    lo_q;
  logic [XLEN-1:0]    wdata_q;
  logic [REGADDR-1:0] wd_out_q;

  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  function automatic logic [2*XLEN-1:0] neg_2x(input logic [2*XLEN-1:0] v, input logic en);
    return en ? -v : v;
  endfunction

  logic            s1_signed, s2_signed, rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_abs, rs2_abs, fast_res;
  logic            div0, ovf, fast, accept, res_neg, last_step;

  assign s1_signed = (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                     (op_i == OP_DIV)  || (op_i == OP_REM);
  assign s2_signed = (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
  assign rs1_neg   = s1_signed & rs1_i[XLEN-1];
  assign rs2_neg   = s2_signed & rs2_i[XLEN-1];
  assign rs1_abs   = neg_x(rs1_i, rs1_neg);
  assign rs2_abs   = neg_x(rs2_i, rs2_neg);
  // Remainder takes the dividend's sign; everything else the XOR of both.
  assign res_neg   = (op_i[2] & op_i[1]) ? rs1_neg : (rs1_neg ^ rs2_neg);

  assign div0     = op_i[2] & (rs2_i == '0);
  assign ovf      = ((op_i == OP_DIV) || (op_i == OP_REM)) && (rs1_i == SMIN) && (rs2_i == '1);
  assign fast     = div0 | ovf;
  assign fast_res = div0 ? (op_i[1] ? rs1_i : '1) : (op_i[1] ? '0 : rs1_i);

  assign accept    = (state_q == IDLE) & start_i & ~flush_i;
  assign last_step = (state_q == CALC) & ~flush_i & (cnt_q == '0);

  // Iteration datapath: UNROLL steps of shift-add or restoring division.
  logic [XLEN-1:0] hi_n, lo_n;
  logic [XLEN:0]   rem_sh, sum;

  always_comb begin
    hi_n   = hi_q;
    lo_n   = lo_q;
    rem_sh = '0;
    sum    = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (op_q[2]) begin
        rem_sh = {hi_n, lo_n[XLEN-1]};
        lo_n   = {lo_n[XLEN-2:0], 1'b0};
        if (rem_sh >= {1'b0, opnd_q}) begin
          rem_sh  = rem_sh - {1'b0, opnd_q};
          lo_n[0] = 1'b1;
        end
        hi_n = rem_sh[XLEN-1:0];
      end else begin
        sum  = lo_n[0] ? ({1'b0, hi_n} + {1'b0, opnd_q}) : {1'b0, hi_n};
        hi_n = sum[XLEN:1];
        lo_n = {sum[0], lo_n[XLEN-1:1]};
      end
    end
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix, rem_fix, calc_res;

  assign prod_fix = neg_2x({hi_n, lo_n}, neg_q);
  assign quot_fix = neg_x(lo_n, neg_q);
  assign rem_fix  = neg_x(hi_n, neg_q);

  always_comb begin
    calc_res = '0;
    unique case (op_q)
      OP_MUL:                       calc_res = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: calc_res = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              calc_res = quot_fix;
      OP_REM, OP_REMU:              calc_res = rem_fix;
      default:                      calc_res = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = fast ? DONE : CALC;
      CALC: begin
        if (flush_i)           state_d = IDLE;
        else if (cnt_q == '0)  state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= '0;
      op_q     <= '0;
      wd_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      wdata_q  <= '0;
      wd_out_q <= '0;
    end else if (accept) begin
      op_q   <= op_i;
      wd_q   <= wd_i;
      neg_q  <= res_neg;
      cnt_q  <= CNT_LAST;
      hi_q   <= '0;
      opnd_q <= op_i[2] ? rs2_abs : rs1_abs;
      lo_q   <= op_i[2] ? rs1_abs : rs2_abs;
      if (fast) begin
        wdata_q  <= fast_res;
        wd_out_q <= wd_i;
      end
    end else if (state_q == CALC) begin
      cnt_q <= cnt_q - CW'(1);
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      if (last_step) begin
        wdata_q  <= calc_res;
        wd_out_q <= wd_q;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE) & ~flush_i;
  assign stall_req_o = rst & ((state_q == CALC) | accept);
  assign wdata_o     = wdata_q;
  assign wd_o        = wd_out_q;
  assign wreg_o      = done_o & (wd_out_q != '0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed RV32M cases on a 32-bit/UNROLL=1 instance and
// randomized ops on a 16-bit/UNROLL=4 instance against a plain-arithmetic model.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sel;
  logic        start, flush;
  logic [2:0]  op;
  logic [31:0] rs1, rs2;
  logic [4:0]  wd;

  logic        stall32, busy32, done32, wreg32;
  logic [31:0] wdata32;
  logic [4:0]  wd32;
  logic        stall16, busy16, done16, wreg16;
  logic [15:0] wdata16;
  logic [4:0]  wd16;

  logic        cur_stall, cur_busy, cur_done, cur_wreg;
  logic [31:0] cur_wdata;
  logic [4:0]  cur_wd;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  ex_muldiv #(.XLEN(32), .UNROLL(1), .REGADDR(5)) dut32 (
    .clk(clk), .rst(rst_n), .start_i(start & ~sel), .op_i(op), .rs1_i(rs1), .rs2_i(rs2),
    .wd_i(wd), .flush_i(flush & ~sel), .stall_req_o(stall32), .busy_o(busy32),
    .done_o(done32), .wdata_o(wdata32), .wd_o(wd32), .wreg_o(wreg32)
  );

  ex_muldiv #(.XLEN(16), .UNROLL(4), .REGADDR(5)) dut16 (
    .clk(clk), .rst(rst_n), .start_i(start & sel), .op_i(op), .rs1_i(rs1[15:0]),
    .rs2_i(rs2[15:0]), .wd_i(wd), .flush_i(flush & sel), .stall_req_o(stall16),
    .busy_o(busy16), .done_o(done16), .wdata_o(wdata16), .wd_o(wd16), .wreg_o(wreg16)
  );

  assign cur_stall = sel ? stall16 : stall32;
  assign cur_busy  = sel ? busy16  : busy32;
  assign cur_done  = sel ? done16  : done32;
  assign cur_wreg  = sel ? wreg16  : wreg32;
  assign cur_wdata = sel ? {16'd0, wdata16} : wdata32;
  assign cur_wd    = sel ? wd16 : wd32;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: RV32M semantics computed with 64-bit arithmetic, result masked to xl bits.
  function automatic logic [31:0] ref_op(input logic [2:0] o, input logic [31:0] a,
                                         input logic [31:0] b, input int xl);
    logic [63:0] mask, ua, ub, sa, sb, r, smin;
    longint qa, qb;
    mask = (64'd1 << xl) - 64'd1;
    smin = 64'd1 << (xl - 1);
    ua = {32'd0, a} & mask;
    ub = {32'd0, b} & mask;
    sa = a[xl-1] ? (ua | ~mask) : ua;
    sb = b[xl-1] ? (ub | ~mask) : ub;
    qa = $signed(sa);
    qb = $signed(sb);
    r  = 64'd0;
    case (o)
      3'b000: r = ua * ub;
      3'b001: r = (sa * sb) >> xl;
      3'b010: r = (sa * ub) >> xl;
      3'b011: r = (ua * ub) >> xl;
      3'b100: begin
        if (ub == 64'd0)                      r = mask;
        else if (ua == smin && ub == mask)    r = ua;
        else                                  r = 64'(qa / qb);
      end
      3'b101: r = (ub == 64'd0) ? mask : ua / ub;
      3'b110: begin
        if (ub == 64'd0)                      r = ua;
        else if (ua == smin && ub == mask)    r = 64'd0;
        else                                  r = 64'(qa % qb);
      end
      default: r = (ub == 64'd0) ? ua : ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic logic [31:0] rand_opnd(input int xl);
    logic [31:0] m;
    m = (xl == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return m;
      2:       return 32'd1 << (xl - 1);
      3:       return 32'd1;
      default: return $urandom;
    endcase
  endfunction

  // Issue one op at a falling edge; ends at a falling edge with the unit idle again.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] w, output logic [31:0] got);
    int xl, lat, seen_at, bad;
    logic [31:0] exp, am, bm, m;
    logic fast;
    xl   = sel ? 16 : 32;
    m    = sel ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    am   = a & m;
    bm   = b & m;
    exp  = ref_op(o, a, b, xl);
    fast = o[2] && ((bm == 32'd0) ||
           ((o == 3'b100 || o == 3'b110) && am == (32'd1 << (xl - 1)) && bm == m));
    lat  = fast ? 1 : ((sel ? 16 / 4 : 32) + 1);
    got  = '0;
    op = o; rs1 = a; rs2 = b; wd = w; start = 1'b1;
    #1;
    chk({tag, "/stall_k"}, 32'(cur_stall), 32'd1);
    @(posedge clk);
    #1 start = 1'b0;
    seen_at = -1;
    bad = 0;
    for (int c = 1; c <= lat + 3 && seen_at < 0; c++) begin
      @(negedge clk);
      if (cur_done === 1'b1) begin
        seen_at = c;
        got = cur_wdata;
        chk({tag, "/wdata"}, cur_wdata, exp);
        chk({tag, "/wd"}, 32'(cur_wd), 32'(w));
        chk({tag, "/wreg"}, 32'(cur_wreg), 32'(w != 5'd0));
        chk({tag, "/stall_done"}, 32'(cur_stall), 32'd0);
      end else if (cur_stall !== 1'b1 || cur_busy !== 1'b1) begin
        bad++;
      end
    end
    chk({tag, "/latency"}, 32'(seen_at), 32'(lat));
    chk({tag, "/stall_calc"}, 32'(bad), 32'd0);
    @(negedge clk);
    chk({tag, "/idle_after"}, {30'd0, cur_busy, cur_done}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got, a, b;
    logic [2:0]  o;
    logic [4:0]  w;
    int bad;

    rst_n = 1'b0; sel = 1'b0; start = 1'b0; flush = 1'b0;
    op = '0; rs1 = '0; rs2 = '0; wd = '0;
    repeat (2) @(negedge clk);
    chk("rst/busy32",  32'(busy32),  32'd0);
    chk("rst/done32",  32'(done32),  32'd0);
    chk("rst/stall32", 32'(stall32), 32'd0);
    chk("rst/wdata32", wdata32,      32'd0);
    chk("rst/wd32",    32'(wd32),    32'd0);
    chk("rst/wreg32",  32'(wreg32),  32'd0);
    chk("rst/busy16",  32'(busy16),  32'd0);
    chk("rst/wdata16", 32'(wdata16), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mul7x6", 3'b000, 32'd7, 32'd6, 5'd3, got);
    chk("mul7x6/lit", got, 32'd42);
    do_op("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, got);
    chk("mulh/lit", got, 32'd0);
    do_op("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, got);
    chk("mulhu/lit", got, 32'hFFFF_FFFE);
    do_op("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, got);
    chk("mulhsu/lit", got, 32'hFFFF_FFFF);
    do_op("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd6, got);
    chk("div/lit", got, 32'hFFFF_FFFD);
    do_op("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 5'd7, got);
    chk("rem/lit", got, 32'hFFFF_FFFF);
    do_op("divu", 3'b101, 32'd100, 32'd7, 5'd8, got);
    chk("divu/lit", got, 32'd14);
    do_op("remu", 3'b111, 32'd100, 32'd7, 5'd9, got);
    chk("remu/lit", got, 32'd2);
    do_op("div0", 3'b100, 32'd1234, 32'd0, 5'd10, got);
    chk("div0/lit", got, 32'hFFFF_FFFF);
    do_op("rem0", 3'b110, 32'd5, 32'd0, 5'd11, got);
    chk("rem0/lit", got, 32'd5);
    do_op("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, got);
    chk("divovf/lit", got, 32'h8000_0000);
    do_op("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, got);
    chk("removf/lit", got, 32'd0);

    // Flush in CALC cycle 10
    op = 3'b000; rs1 = 32'd5; rs2 = 32'd5; wd = 5'd1; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    chk("flush_calc/done", 32'(cur_done), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_calc/busy", 32'(cur_busy), 32'd0);
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (cur_done !== 1'b0 || cur_busy !== 1'b0) bad++;
    end
    chk("flush_calc/quiet", 32'(bad), 32'd0);
    do_op("mul3x3", 3'b000, 32'd3, 32'd3, 5'd2, got);
    chk("mul3x3/lit", got, 32'd9);

    // Flush in DONE (fast-path divide) suppresses the write-back
    op = 3'b101; rs1 = 32'd9; rs2 = 32'd0; wd = 5'd3; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    flush = 1'b1;
    #1;
    chk("flush_done/done", 32'(cur_done), 32'd0);
    chk("flush_done/wreg", 32'(cur_wreg), 32'd0);
    chk("flush_done/busy", 32'(cur_busy), 32'd1);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_done/idle", {30'd0, cur_busy, cur_done}, 32'd0);

    // Flush together with start in IDLE: op not accepted
    op = 3'b000; rs1 = 32'd2; rs2 = 32'd2; wd = 5'd4; start = 1'b1; flush = 1'b1;
    #1;
    chk("flush_start/stall", 32'(cur_stall), 32'd0);
    @(posedge clk);
    #1 begin start = 1'b0; flush = 1'b0; end
    @(negedge clk);
    chk("flush_start/busy", 32'(cur_busy), 32'd0);

    // Randomized sweep on the 16-bit, UNROLL=4 instance
    sel = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_opnd(16);
      b = rand_opnd(16);
      w = 5'($urandom_range(0, 31));
      do_op("rnd16", o, a, b, w, got);
    end
    sel = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      a = rand_opnd(32);
      b = rand_opnd(32);
      w = 5'($urandom_range(0, 31));
      do_op("rnd32", o, a, b, w, got);
    end

    // Asynchronous reset in the middle of CALC
    op = 3'b000; rs1 = 32'h1234; rs2 = 32'h5678; wd = 5'd7; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid/busy",  32'(busy32),  32'd0);
    chk("rst_mid/done",  32'(done32),  32'd0);
    chk("rst_mid/stall", 32'(stall32), 32'd0);
    chk("rst_mid/wdata", wdata32,      32'd0);
    chk("rst_mid/wd",    32'(wd32),    32'd0);
    chk("rst_mid/wreg",  32'(wreg32),  32'd0);
    chk("rst_mid/wdata16", 32'(wdata16), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op("post_rst", 3'b000, 32'd11, 32'd13, 5'd1, got);
    chk("post_rst/lit", got, 32'd143);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
